// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
//   Shared types and helpers for the parallel-in/serial-out serializer.
//   - piso_state_e : serializer FSM state (IDLE waits for a word, SHIFT drains it)
//   - cnt_w()      : width of the bit counter for a given word width
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Bit counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/dff_async_rst_n_en.sv
// -----------------------------------------------------------------------------
// dff_async_rst_n_en
//   Generic enabled register with asynchronous active-low reset.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset, loads RST_VAL
//   i_en     load enable
//   i_d      next value
//   o_q      registered value
// -----------------------------------------------------------------------------
module dff_async_rst_n_en #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Storage element: async clear, enabled capture otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end else begin
      o_q <= o_q;
    end
  end

endmodule

// File: rtl/piso_serializer_async_rst_n.sv
// -----------------------------------------------------------------------------
// piso_serializer_async_rst_n
//   Accepts a WIDTH-bit word over valid/ready and shifts it out one bit per
//   ser_en-high cycle, with first/last framing. A new word can be accepted on
//   the last bit of the current one, so consecutive words stream without gaps.
// Ports:
//   clk          rising-edge clock
//   async_rst_n  asynchronous active-low reset
//   in_valid     in_data is valid
//   in_ready     a word is accepted this cycle if in_valid is high
//   in_data      parallel word
//   ser_en       serial-side shift enable (0 freezes all serial state)
//   ser_out      current serial bit (0 when no word is active)
//   ser_valid    ser_out carries a data bit
//   ser_first    ser_out is the first bit of its word
//   ser_last     ser_out is the last bit of its word
// -----------------------------------------------------------------------------
module piso_serializer_async_rst_n
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last
);

  localparam int             CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_serializer_async_rst_n: WIDTH must be >= 2");
  end

  logic [0:0]       r_state_bits;
  piso_state_e      w_state;
  piso_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_shifted;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_cnt_last;
  logic             w_advance;
  logic             w_load;
  logic             w_out_bit;

  // State register kept in the shared flop cell; always enabled.
  dff_async_rst_n_en #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_state_reg (
    .i_clk   (clk),
    .i_rst_n (async_rst_n),
    .i_en    (1'b1),
    .i_d     (w_state_nxt),
    .o_q     (r_state_bits)
  );

  assign w_state    = piso_state_e'(r_state_bits);
  assign w_cnt_last = (r_bit_cnt == CNT_LAST);
  // Serial state only moves while a word is active and the link is enabled.
  assign w_advance  = (w_state == SHIFT) & ser_en;
  assign w_load     = in_valid & in_ready;

  // Vacated positions fill with zero; direction chosen by MSB_FIRST.
  assign w_shreg_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_out_bit       = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

  // Next-state logic: leave SHIFT only after the last bit with nothing queued.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (ser_en && w_cnt_last) begin
          w_state_nxt = in_valid ? SHIFT : IDLE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: ready is independent of in_valid to avoid a comb loop upstream.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    ser_out   = 1'b0;
    case (w_state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        in_ready  = w_cnt_last & ser_en;
        ser_valid = 1'b1;
        ser_first = (r_bit_cnt == {CNT_W{1'b0}});
        ser_last  = w_cnt_last;
        ser_out   = w_out_bit;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Shift register: load takes priority so a back-to-back word replaces the last bit.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_shreg <= {WIDTH{1'b0}};
    end else if (w_load) begin
      r_shreg <= in_data;
    end else if (w_advance) begin
      r_shreg <= w_shreg_shifted;
    end else begin
      r_shreg <= r_shreg;
    end
  end

  // Bit counter: returns to 0 after the last bit instead of running through unused codes.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_bit_cnt <= {CNT_W{1'b0}};
    end else if (w_load) begin
      r_bit_cnt <= {CNT_W{1'b0}};
    end else if (w_advance) begin
      r_bit_cnt <= w_cnt_last ? {CNT_W{1'b0}} : (r_bit_cnt + CNT_W'(1));
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

endmodule

// File: tb/tb_piso_serializer_async_rst_n.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer_async_rst_n
//   Drives two serializers (LSB-first and MSB-first) with the same stimulus and
//   checks them against a word/index model every cycle, plus literal expectations
//   for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_piso_serializer_async_rst_n;

  logic       clk;
  logic       async_rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_en;

  logic rdy_l, out_l, val_l, fst_l, lst_l;
  logic rdy_m, out_m, val_m, fst_m, lst_m;

  piso_serializer_async_rst_n #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .in_valid    (in_valid),
    .in_ready    (rdy_l),
    .in_data     (in_data),
    .ser_en      (ser_en),
    .ser_out     (out_l),
    .ser_valid   (val_l),
    .ser_first   (fst_l),
    .ser_last    (lst_l)
  );

  piso_serializer_async_rst_n #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .in_valid    (in_valid),
    .in_ready    (rdy_m),
    .in_data     (in_data),
    .ser_en      (ser_en),
    .ser_out     (out_m),
    .ser_valid   (val_m),
    .ser_first   (fst_m),
    .ser_last    (lst_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the word being sent and how many of its bits have already gone out.
  logic       m_active = 1'b0;
  logic [7:0] m_word   = 8'h00;
  int         m_idx    = 0;

  always @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      m_active <= 1'b0;
      m_word   <= 8'h00;
      m_idx    <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_word   <= in_data;
        m_idx    <= 0;
      end
    end else if (ser_en) begin
      if (m_idx < 7) begin
        m_idx <= m_idx + 1;
      end else if (in_valid) begin
        m_word <= in_data;
        m_idx  <= 0;
      end else begin
        m_active <= 1'b0;
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  // Scenario monitor, written only by the stimulus process.
  int         vcnt, runs, fcnt, lcnt, rcnt, ecnt, fpos, lpos;
  logic       prev_v;
  logic [7:0] cap_l, cap_m;
  logic       last_ready, last_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    vcnt = 0; runs = 0; fcnt = 0; lcnt = 0; rcnt = 0; ecnt = 0;
    fpos = 0; lpos = 0; prev_v = 1'b0; cap_l = 8'h00; cap_m = 8'h00;
  endtask

  // One cycle: compare against the model at the falling edge, record, advance.
  task automatic tick();
    logic e_rdy, e_out_l, e_out_m, e_fst, e_lst;
    @(negedge clk);
    e_rdy   = !m_active || (m_idx == 7 && ser_en);
    e_out_l = m_active ? m_word[m_idx] : 1'b0;
    e_out_m = m_active ? m_word[7 - m_idx] : 1'b0;
    e_fst   = m_active && (m_idx == 0);
    e_lst   = m_active && (m_idx == 7);
    check("ready_lsb", rdy_l, e_rdy);
    check("valid_lsb", val_l, m_active);
    check("out_lsb",   out_l, e_out_l);
    check("first_lsb", fst_l, e_fst);
    check("last_lsb",  lst_l, e_lst);
    check("ready_msb", rdy_m, e_rdy);
    check("valid_msb", val_m, m_active);
    check("out_msb",   out_m, e_out_m);
    check("first_msb", fst_m, e_fst);
    check("last_msb",  lst_m, e_lst);
    if (val_l) vcnt++;
    if (val_l && !prev_v) runs++;
    prev_v = val_l;
    if (val_l && fst_l) begin fcnt++; fpos = vcnt; end
    if (val_l && lst_l) begin lcnt++; lpos = vcnt; end
    if (val_l && rdy_l && in_valid) rcnt++;
    if (val_l && ser_en) begin
      cap_l = {out_l, cap_l[7:1]};
      cap_m = {cap_m[6:0], out_m};
      ecnt++;
    end
    last_ready = rdy_l;
    last_valid = val_l;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [7:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_ready && n < 64);
    check("accept_timeout", last_ready, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_valid && n < 64);
    check("idle_timeout", last_valid, 1'b0);
  endtask

  initial begin
    async_rst_n = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    ser_en      = 1'b1;
    last_ready  = 1'b0;
    last_valid  = 1'b0;
    clear_mon();

    // 1: reset takes effect before any clock edge
    #2 async_rst_n = 1'b0;
    #1;
    check("rst_ready", rdy_l, 1'b1);
    check("rst_valid", val_l, 1'b0);
    check("rst_out",   out_l, 1'b0);
    check("rst_first", fst_m, 1'b0);
    check("rst_last",  lst_m, 1'b0);
    tick();
    tick();
    async_rst_n = 1'b1;
    tick();

    // 2: single word A5
    clear_mon();
    drive_word(8'hA5);
    in_valid = 1'b0;
    wait_idle();
    check("a5_bits_lsb", cap_l, 8'hA5);
    check("a5_bits_msb", cap_m, 8'hA5);
    check("a5_len",      vcnt, 8);
    check("a5_first_at", fpos, 1);
    check("a5_last_at",  lpos, 8);

    // 3: back-to-back 0F, F0 with in_valid held
    clear_mon();
    drive_word(8'h0F);
    drive_word(8'hF0);
    in_valid = 1'b0;
    wait_idle();
    check("b2b_len",    vcnt, 16);
    check("b2b_runs",   runs, 1);
    check("b2b_accept", rcnt, 1);
    check("b2b_firsts", fcnt, 2);
    check("b2b_lasts",  lcnt, 2);
    check("b2b_word2",  cap_l, 8'hF0);

    // 4: stall 3 cycles while bit 2 of 81 is on the line
    clear_mon();
    drive_word(8'h81);
    in_valid = 1'b0;
    tick();
    tick();
    ser_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", val_l, 1'b1);
      check("stall_out_lsb", out_l, 1'b0);
      check("stall_first", fst_l, 1'b0);
      check("stall_last", lst_l, 1'b0);
    end
    ser_en = 1'b1;
    wait_idle();
    check("stall_bits", ecnt, 8);
    check("stall_cycles", vcnt, 11);
    check("stall_word_lsb", cap_l, 8'h81);
    check("stall_word_msb", cap_m, 8'h81);

    // 5: C0, MSB-first order is 1,1,0,0,0,0,0,0
    clear_mon();
    drive_word(8'hC0);
    in_valid = 1'b0;
    wait_idle();
    check("c0_msb", cap_m, 8'hC0);
    check("c0_lsb", cap_l, 8'hC0);

    // 6: reset mid-word at bit 4 of FF, then 01 from a clean start
    clear_mon();
    drive_word(8'hFF);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 async_rst_n = 1'b0;
    #1;
    check("midrst_valid", val_l, 1'b0);
    check("midrst_out",   out_l, 1'b0);
    check("midrst_ready", rdy_l, 1'b1);
    check("midrst_vmsb",  val_m, 1'b0);
    tick();
    async_rst_n = 1'b1;
    clear_mon();
    drive_word(8'h01);
    in_valid = 1'b0;
    wait_idle();
    check("post_rst_lsb",   cap_l, 8'h01);
    check("post_rst_msb",   cap_m, 8'h01);
    check("post_rst_bits",  ecnt, 8);
    check("post_rst_first", fpos, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
